// File: rtl/rc5_key_schedule_ctrl.sv
// RC5-w/r/b key expansion controller: loads key bytes into L, initialises S from
// Pw/Qw, then runs 3*max(T,C) mixing steps. S is exposed through a random-access read port.
module rc5_key_schedule_ctrl #(
    parameter int W   = 32,
    parameter int B   = 16,
    parameter int T   = 26,
    parameter int U   = 4,
    parameter int C   = 4,
    parameter int LGW = 5,
    parameter int AW  = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [8*B-1:0] key,
    input  logic [W-1:0]   pw,
    input  logic [W-1:0]   qw,
    output logic           busy,
    output logic           done,
    output logic           key_valid,
    input  logic [AW-1:0]  s_raddr,
    output logic [W-1:0]   s_rdata
);
    localparam int N  = 3 * ((T > C) ? T : C);
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int NW = $clog2(N + 1);

    typedef enum logic [2:0] {IDLE, LOAD, INIT, MIX, DONE} state_t;
    state_t state, state_next;

    logic [8*B-1:0] key_r;
    logic [W-1:0]   l_tab [C];
    logic [W-1:0]   s_tab [T];
    logic [W-1:0]   mix_a, mix_b;
    logic [7:0]     byte_idx;
    logic [AW-1:0]  s_idx;
    logic [CW-1:0]  l_idx;
    logic [NW-1:0]  step;
    logic           done_r;

    logic [CW-1:0]  load_lidx;
    logic [7:0]     key_byte;
    logic [W-1:0]   init_word;
    logic [W-1:0]   a_new, b_new;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LGW-1:0] amt);
        logic [2*W-1:0] t;
        t = {x, x} << amt;
        return t[2*W-1:W];
    endfunction

    always_comb begin
        load_lidx = CW'(byte_idx / U);
        key_byte  = 8'(key_r >> {byte_idx, 3'b000});
        // During INIT mix_a carries the previous S word, so S[k-1] is never re-read
        init_word = (s_idx == '0) ? pw : mix_a + qw;
        a_new     = rotl(s_tab[s_idx] + mix_a + mix_b, LGW'(3));
        b_new     = rotl(l_tab[l_idx] + a_new + mix_b, LGW'(a_new + mix_b));
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        key_valid  = 1'b0;
        done       = done_r;
        unique case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                busy = 1'b1;
                if (byte_idx == '0) state_next = INIT;
            end
            INIT: begin
                busy = 1'b1;
                if (s_idx == AW'(T - 1)) state_next = MIX;
            end
            MIX: begin
                busy = 1'b1;
                if (step == NW'(N - 1)) state_next = DONE;
            end
            DONE: begin
                key_valid = 1'b1;
                if (start) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_r    <= '0;
            mix_a    <= '0;
            mix_b    <= '0;
            byte_idx <= '0;
            s_idx    <= '0;
            l_idx    <= '0;
            step     <= '0;
            done_r   <= 1'b0;
            for (int unsigned idx = 0; idx < C; idx++) l_tab[idx] <= '0;
            for (int unsigned idx = 0; idx < T; idx++) s_tab[idx] <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        key_r    <= key;
                        byte_idx <= 8'(B - 1);
                        for (int unsigned idx = 0; idx < C; idx++) l_tab[idx] <= '0;
                    end
                end
                LOAD: begin
                    l_tab[load_lidx] <= rotl(l_tab[load_lidx], LGW'(8)) + W'(key_byte);
                    byte_idx <= byte_idx - 1'b1;
                    if (byte_idx == '0) s_idx <= '0;
                end
                INIT: begin
                    s_tab[s_idx] <= init_word;
                    mix_a        <= init_word;
                    s_idx        <= s_idx + 1'b1;
                    if (s_idx == AW'(T - 1)) begin
                        s_idx <= '0;
                        l_idx <= '0;
                        step  <= '0;
                        mix_a <= '0;
                        mix_b <= '0;
                    end
                end
                MIX: begin
                    s_tab[s_idx] <= a_new;
                    l_tab[l_idx] <= b_new;
                    mix_a        <= a_new;
                    mix_b        <= b_new;
                    s_idx        <= (s_idx == AW'(T - 1)) ? '0 : s_idx + 1'b1;
                    l_idx        <= (l_idx == CW'(C - 1)) ? '0 : l_idx + 1'b1;
                    step         <= step + 1'b1;
                    if (step == NW'(N - 1)) done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_rdata = '0;
        if ({1'b0, s_raddr} < (AW + 1)'(T)) s_rdata = s_tab[s_raddr];
    end

endmodule

// File: tb/tb_rc5_key_schedule_ctrl.sv
// Directed bench for rc5_key_schedule_ctrl: handshake timing, snooped INIT/LOAD
// values, final S against an RC5 reference model, restart and reset behaviour.
module tb_rc5_key_schedule_ctrl;
    localparam int W   = 32;
    localparam int B   = 16;
    localparam int T   = 26;
    localparam int U   = 4;
    localparam int C   = 4;
    localparam int LGW = 5;
    localparam int AW  = 5;
    localparam int LAT = 121;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [8*B-1:0] key;
    logic [W-1:0]   pw, qw;
    logic           busy, done, key_valid;
    logic [AW-1:0]  s_raddr;
    logic [W-1:0]   s_rdata;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m_s [T];
    logic [W-1:0] m_l [C];
    logic [W-1:0] snoop_s [3];
    logic [W-1:0] snoop_l [C];
    logic         kv_first;
    int           done_cyc, busy_cnt, done_cnt;

    rc5_key_schedule_ctrl #(
        .W(W), .B(B), .T(T), .U(U), .C(C), .LGW(LGW), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .pw(pw), .qw(qw),
        .busy(busy), .done(done), .key_valid(key_valid),
        .s_raddr(s_raddr), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_rotl(input logic [W-1:0] x, input int y);
        int r;
        r = y & (W - 1);
        return (x << r) | (x >> (W - r));
    endfunction

    task automatic build_model(input logic [8*B-1:0] k);
        logic [W-1:0] a, b;
        logic [7:0]   kb;
        int           i, j;
        for (int c = 0; c < C; c++) m_l[c] = '0;
        for (int x = B - 1; x >= 0; x--) begin
            kb = k[8*x +: 8];
            m_l[x/U] = (m_l[x/U] << 8) + W'(kb);
        end
        m_s[0] = pw;
        for (int x = 1; x < T; x++) m_s[x] = m_s[x-1] + qw;
        a = '0; b = '0; i = 0; j = 0;
        for (int n = 0; n < 3 * ((T > C) ? T : C); n++) begin
            a = ref_rotl(m_s[i] + a + b, 3);
            m_s[i] = a;
            b = ref_rotl(m_l[j] + a + b, int'(a + b));
            m_l[j] = b;
            i = (i + 1) % T;
            j = (j + 1) % C;
        end
    endtask

    // Pulses start for one edge, optionally re-pulses it at cycles p0..p2, and
    // records timing plus snooped L (after LOAD) and S[0..2] (after INIT).
    task automatic expand(input int p0, input int p1, input int p2);
        done_cyc = -1; busy_cnt = 0; done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) kv_first = key_valid;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == B + 1)
                for (int x = 0; x < C; x++) snoop_l[x] = dut.l_tab[x];
            if (c == B + T + 1)
                for (int x = 0; x < 3; x++) begin
                    s_raddr = AW'(x);
                    #1 snoop_s[x] = s_rdata;
                end
            start = (c == p0 || c == p1 || c == p2);
            if (done_cyc > 0 && c >= done_cyc + 2) break;
        end
        start = 1'b0;
    endtask

    task automatic check_final_s(input string tag);
        for (int a = 0; a < T; a++) begin
            s_raddr = AW'(a);
            #1 check_eq($sformatf("%s_s[%0d]", tag, a), s_rdata, m_s[a]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; key = '0; s_raddr = '0;
        pw = 32'hB7E15163; qw = 32'h9E3779B9;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_kv", key_valid, 0);
        for (int a = 0; a < 32; a++) begin
            s_raddr = AW'(a);
            #1 check_eq($sformatf("rst_s[%0d]", a), s_rdata, 0);
        end

        // Zero key
        key = '0;
        build_model(key);
        expand(0, 0, 0);
        check_eq("z_done_cyc", done_cyc, LAT);
        check_eq("z_busy_cnt", busy_cnt, LAT - 1);
        check_eq("z_done_cnt", done_cnt, 1);
        check_eq("z_kv_first", kv_first, 0);
        check_eq("z_kv_hold", key_valid, 1);
        check_eq("z_done_low", done, 0);
        check_eq("z_init_s0", snoop_s[0], 32'hB7E15163);
        check_eq("z_init_s1", snoop_s[1], 32'h5618CB1C);
        check_eq("z_init_s2", snoop_s[2], 32'hF45044D5);
        check_final_s("z");

        // Key bytes 0x00..0x0F
        key = 128'h0F0E0D0C0B0A09080706050403020100;
        build_model(key);
        expand(0, 0, 0);
        check_eq("k_done_cyc", done_cyc, LAT);
        check_eq("k_l0", snoop_l[0], 32'h03020100);
        check_eq("k_l1", snoop_l[1], 32'h07060504);
        check_eq("k_l2", snoop_l[2], 32'h0B0A0908);
        check_eq("k_l3", snoop_l[3], 32'h0F0E0D0C);
        check_final_s("k");

        // Start pulses while busy are ignored
        key = '0;
        build_model(key);
        expand(5, 60, 119);
        check_eq("ign_done_cyc", done_cyc, LAT);
        check_eq("ign_done_cnt", done_cnt, 1);
        check_eq("ign_busy_cnt", busy_cnt, LAT - 1);
        check_final_s("ign");

        // Restart from DONE
        check_eq("re_kv_before", key_valid, 1);
        expand(0, 0, 0);
        check_eq("re_kv_first", kv_first, 0);
        check_eq("re_done_cyc", done_cyc, LAT);
        check_eq("re_done_cnt", done_cnt, 1);
        check_final_s("re");

        // Asynchronous reset mid-MIX
        key = 128'h0F0E0D0C0B0A09080706050403020100;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (79) @(negedge clk);
        check_eq("mr_busy_pre", busy, 1);
        #2 rst = 1'b1;
        s_raddr = '0;
        #1;
        check_eq("mr_busy", busy, 0);
        check_eq("mr_done", done, 0);
        check_eq("mr_kv", key_valid, 0);
        check_eq("mr_s0", s_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (150) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_eq("mr_no_done", done_cnt, 0);
        check_eq("mr_kv_idle", key_valid, 0);
        build_model(key);
        expand(0, 0, 0);
        check_eq("mr_done_cyc", done_cyc, LAT);
        check_final_s("mr");

        // Out-of-range read addresses
        for (int a = T; a < 32; a++) begin
            s_raddr = AW'(a);
            #1 check_eq($sformatf("oor_s[%0d]", a), s_rdata, 0);
        end
        s_raddr = AW'(T - 1);
        #1 check_eq("last_s", s_rdata, m_s[T-1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rc5_key_schedule_ctrl.md
Name: rc5_key_schedule_ctrl

Overview:
Sequences the complete RC5-w/r/b key expansion over a shared single-adder datapath:
- key bytes to words (L array);
- S-table initialisation from Pw/Qw;
- 3·max(T,C) mixing passes.

Holds L and S internally. Exposes a start/done handshake and a random-access S read port that the encrypt/decrypt core uses once key_valid is high.

Parameters:
W, 32, word width in bits (power of 2, 16..64)
B, 16, key length in bytes (1..255)
T, 26, S-table size (2r+2)
U, 4, bytes per word (W/8)
C, 4, L words = max(1, ceil(B/U))
LGW, 5, log2(W), rotation-amount width
AW, 5, S address width, ceil(log2(T))

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request key expansion; sampled only in IDLE or DONE
key  in  8*B  key bytes, byte i = key[8i+7:8i]; captured on accepted start
pw  in  W  magic constant P for W
qw  in  W  magic constant Q for W
busy  out  1  high while expansion is in progress
done  out  1  one-cycle pulse when S is final
key_valid  out  1  S table holds a completed schedule
s_raddr  in  AW  S read address
s_rdata  out  W  S[s_raddr], combinational; 0 if s_raddr >= T

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, key_valid=0; all L[], S[], A, B, counters = 0; latched key = 0.
- States: IDLE, LOAD, INIT, MIX, DONE.
- IDLE/DONE + start=1:
  - latch key; L[] cleared to 0;
  - busy=1, key_valid=0 from the next cycle;
  - go to LOAD with i=B-1.
- start while busy=1: ignored, no effect.
- LOAD, one byte per cycle, i=B-1 down to 0:
  - L[i/U] <= (L[i/U] rotl 8) + zero-extended key byte i, mod 2^W;
  - after i=0, go to INIT with k=0.
- INIT, one word per cycle:
  - S[0] <= pw;
  - S[k] <= S[k-1] + qw, mod 2^W, k=1..T-1;
  - after k=T-1, go to MIX with i=j=0, A=B=0, n=0.
- MIX, one step per cycle, N = 3·max(T,C) steps:
  - A' = (S[i] + A + B) rotl 3;
  - B' = (L[j] + A' + B) rotl ((A'+B) mod W), amount = low LGW bits;
  - S[i] <= A', L[j] <= B', A <= A', B <= B';
  - i <= (i+1) mod T, j <= (j+1) mod C, n <= n+1;
  - when n=N-1, go to DONE.
- Entry to DONE: done=1 for exactly that cycle; busy=0; key_valid=1.
  - DONE holds, key_valid stays 1 until the next accepted start or reset.
- Latency: start sampled at edge 0 → busy high edges 1..B+T+N → done high in cycle B+T+N+1.
  - Defaults: 16+26+78 = 120 busy cycles; done in cycle 121.
- Wrap-around: i and j wrap independently. With C < T, L words are revisited every C steps.
- Rotation by 0 (A'+B ≡ 0 mod W) leaves the word unchanged.
- s_rdata is valid at any time but is meaningful only when key_valid=1. During busy it shows in-progress values.
- start and rst together: rst wins.
- Reset mid-MIX: key_valid stays 0, and no done pulse is produced.

Test Plan:
1. Reset then idle, no start → busy=0, done=0, key_valid=0, s_rdata=0 for every address 0..31.
2. B=16 zero key, pw=B7E15163, qw=9E3779B9, start 1 cycle → done in cycle 121; after INIT (snoop) S[0]=B7E15163, S[1]=5618CB1C, S[2]=F45044D5; final S[0..25] matches C reference model; key_valid=1.
3. key bytes 0x00..0x0F → L after LOAD = {03020100, 07060504, 0B0A0908, 0F0E0D0C}; final S matches model.
4. start pulsed at cycles 5, 60, 119 during an expansion → single done at 121, S unchanged vs scenario 2; second start in DONE → key_valid drops next cycle, new done 120 cycles later.
5. rst asserted mid-MIX (cycle 80) → all outputs 0 asynchronously; no done pulse; a fresh start completes normally.
6. s_raddr=26..31 with key_valid=1 → s_rdata=0; s_raddr=25 → model S[25].
